rgb_expand_fade: RTL and testbench
==================================

Name: rgb_expand_fade

Overview:
- Parametrised RGB expander: widens IN_BITS-per-channel video to OUT_BITS per channel by MSB-first bit replication, then scales by a global brightness level.
- Sits between the overlay/graphics generator and the RGB output mixer, in the 81 MHz video clock domain.
- Syncs, blank and valid are pipelined alongside the pixels so they stay aligned with them.
- A frame-synchronous fade engine ramps brightness up or down over a set number of frames.

Parameters:
- IN_BITS, 1, bits per input channel (1..8).
- OUT_BITS, 6, bits per output channel (IN_BITS..10).
- LEVEL_LOG2, 4. Brightness levels run 0..2^LEVEL_LOG2 inclusive; full scale is 2^LEVEL_LOG2.
- FRAMES_PER_STEP, 2, vsync rising edges per one-level fade step (1..255).

Ports:
- clk  in  1  video clock, 81 MHz
- reset  in  1  synchronous, active-high reset
- pix_valid_in  in  1  input pixel qualifier
- red_in / green_in / blue_in  in  IN_BITS each  input channels
- hsync_in / vsync_in / blank_in  in  1 each  timing; blank_in=1 forces black
- fade_start  in  1  single-cycle fade request
- fade_dir  in  1  1 = fade in (toward full), 0 = fade out (toward 0); sampled with fade_start
- fade_busy  out  1  high while a fade is in progress
- level_out  out  LEVEL_LOG2+1  current brightness level
- red_out / green_out / blue_out  out  OUT_BITS each  scaled output channels
- hsync_out / vsync_out / pix_valid_out  out  1 each  delayed copies of the inputs

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - All colour outputs, hsync_out, vsync_out, pix_valid_out and fade_busy are 0.
  - level_out = 2^LEVEL_LOG2 (full brightness).
  - The vsync edge register and the frame counter are cleared.
  - FSM state is IDLE.
- Stage 1, registered:
  - Each channel is expanded to OUT_BITS by repeating the input value MSB-first and truncating to OUT_BITS (1 -> 111111; 2'b10 -> 101010).
  - blank_in=1 forces the expanded value to 0.
- Stage 2, registered: out = (expanded * level) >> LEVEL_LOG2, unsigned. The product is OUT_BITS+LEVEL_LOG2+1 wide, so there is no overflow. At full level the output equals expanded exactly.
- Latency:
  - Exactly 2 clk for colour, hsync, vsync and pix_valid.
  - The pipeline advances every cycle, with no stall.
  - pix_valid only qualifies pixels; it does not gate the pipeline.
- Level usage: the level used in stage 2 is level_out as registered. Level changes occur only on a vsync rising edge, so the level is constant within a frame.
- Vsync edge detection: a vsync rising edge is vsync_in=1 with the previous cycle's vsync_in=0.
- FSM states: IDLE, FADE_IN, FADE_OUT.
  - IDLE + fade_start, fade_dir=1, level < max -> FADE_IN; frame counter cleared.
  - IDLE + fade_start, fade_dir=0, level > 0 -> FADE_OUT; frame counter cleared.
  - IDLE + fade_start when level is already at the target -> stays IDLE; fade_busy stays 0.
  - FADE_x: on each vsync rising edge the frame counter increments. When it reaches FRAMES_PER_STEP it clears and level steps by ±1.
  - When level reaches max (FADE_IN) or 0 (FADE_OUT), return to IDLE on that same edge.
  - fade_busy = 1 in FADE_IN and FADE_OUT (registered from the state).
- Boundary conditions:
  - fade_start while busy: ignored, and the direction is not changed.
  - fade_start coincident with a vsync edge in IDLE: the FSM enters the fade state. That edge is not counted.
  - Reset mid-fade: the FSM returns to IDLE and level returns to full on the next clk. The pipeline contents are zeroed.
  - Level never wraps below 0 or above 2^LEVEL_LOG2.

Optional Feature:
- Macro: RGB_EXPAND_FADE_KEY_EN.
- When defined:
  - Add parameter KEY_COLOUR (3*IN_BITS bits, default 0).
  - Add output key_out (1 bit), 2-clk aligned with the pixels. key_out=1 when pix_valid_in=1, blank_in=0 and {red_in,green_in,blue_in} == KEY_COLOUR.
  - key_out resets to 0.
  - key_out is independent of the fade level, so the mixer can treat keyed pixels as transparent.
- When undefined: there is no key_out port and no compare logic. All other behaviour is identical.

Test Plan:
- IN_BITS=1, OUT_BITS=6, reset released, input R=1 G=0 B=1 -> after 2 clk: red_out=63, green_out=0, blue_out=63. Syncs delayed by exactly 2 clk.
- IN_BITS=2, OUT_BITS=6, input R=2'b10, G=2'b01, B=2'b11 -> red_out=42, green_out=21, blue_out=63. blank_in=1 -> all 0.
- LEVEL_LOG2=4, FRAMES_PER_STEP=2, fade_start with fade_dir=0 -> fade_busy=1. level steps 16->15 on the 2nd vsync edge and reaches 0 after 32 edges, then fade_busy=0. With input 1 at level 8, output = 31.
- Fade in from level 0 with a second fade_start (fade_dir=0) mid-fade -> the second request is ignored and level keeps rising to 16. fade_start at level 16 with fade_dir=1 -> fade_busy stays 0.
- Reset asserted at level 5 mid fade-out -> next clk: level_out=16, fade_busy=0, all outputs 0.
- With RGB_EXPAND_FADE_KEY_EN defined and KEY_COLOUR=3'b000, black valid unblanked pixel -> key_out=1 two clk later. Same pixel with blank_in=1 -> key_out=0.

Source files
------------

// File: rtl/rgb_expand_fade.sv
// rtl/rgb_expand_fade.sv - RGB bit-replication expander with frame-synchronous brightness fade
// Optional colour-key output enabled by defining RGB_EXPAND_FADE_KEY_EN
module rgb_expand_fade #(
    parameter int IN_BITS         = 1,
    parameter int OUT_BITS        = 6,
    parameter int LEVEL_LOG2      = 4,
    parameter int FRAMES_PER_STEP = 2
`ifdef RGB_EXPAND_FADE_KEY_EN
    ,
    parameter logic [3*IN_BITS-1:0] KEY_COLOUR = '0
`endif
) (
`ifdef RGB_EXPAND_FADE_KEY_EN
    output logic                  key_out,
`endif
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_valid_in,
    input  logic [IN_BITS-1:0]    red_in,
    input  logic [IN_BITS-1:0]    green_in,
    input  logic [IN_BITS-1:0]    blue_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  blank_in,
    input  logic                  fade_start,
    input  logic                  fade_dir,
    output logic                  fade_busy,
    output logic [LEVEL_LOG2:0]   level_out,
    output logic [OUT_BITS-1:0]   red_out,
    output logic [OUT_BITS-1:0]   green_out,
    output logic [OUT_BITS-1:0]   blue_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  pix_valid_out
);

    localparam int REPS = (OUT_BITS + IN_BITS - 1) / IN_BITS;
    localparam int RW   = REPS * IN_BITS;
    localparam int PW   = OUT_BITS + LEVEL_LOG2 + 1;
    localparam logic [LEVEL_LOG2:0] LVL_MAX = {1'b1, {LEVEL_LOG2{1'b0}}};
    localparam logic [LEVEL_LOG2:0] LVL_ONE = {{LEVEL_LOG2{1'b0}}, 1'b1};
    localparam logic [7:0]          CNT_LAST = 8'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {IDLE, FADE_IN, FADE_OUT} state_t;

    // Repeat the value MSB-first, keep the top OUT_BITS of the replicated word.
    function automatic logic [OUT_BITS-1:0] expand(input logic [IN_BITS-1:0] v);
        return OUT_BITS'({REPS{v}} >> (RW - OUT_BITS));
    endfunction

    function automatic logic [OUT_BITS-1:0] scale(input logic [OUT_BITS-1:0] v,
                                                  input logic [LEVEL_LOG2:0] lvl);
        return OUT_BITS'((PW'(v) * PW'(lvl)) >> LEVEL_LOG2);
    endfunction

    logic [OUT_BITS-1:0] exp_r, exp_g, exp_b;
    logic                hs_1, vs_1, pv_1;
    state_t              state;
    logic [7:0]          frame_cnt;
    logic                vs_prev;
    logic                vs_rise;
    logic                step_due;

    assign vs_rise  = vsync_in && !vs_prev;
    assign step_due = (frame_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_r         <= '0;
            exp_g         <= '0;
            exp_b         <= '0;
            hs_1          <= 1'b0;
            vs_1          <= 1'b0;
            pv_1          <= 1'b0;
            red_out       <= '0;
            green_out     <= '0;
            blue_out      <= '0;
            hsync_out     <= 1'b0;
            vsync_out     <= 1'b0;
            pix_valid_out <= 1'b0;
        end else begin
            exp_r         <= blank_in ? '0 : expand(red_in);
            exp_g         <= blank_in ? '0 : expand(green_in);
            exp_b         <= blank_in ? '0 : expand(blue_in);
            hs_1          <= hsync_in;
            vs_1          <= vsync_in;
            pv_1          <= pix_valid_in;
            red_out       <= scale(exp_r, level_out);
            green_out     <= scale(exp_g, level_out);
            blue_out      <= scale(exp_b, level_out);
            hsync_out     <= hs_1;
            vsync_out     <= vs_1;
            pix_valid_out <= pv_1;
        end
    end

`ifdef RGB_EXPAND_FADE_KEY_EN
    logic key_1;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_1   <= 1'b0;
            key_out <= 1'b0;
        end else begin
            key_1   <= pix_valid_in && !blank_in &&
                       ({red_in, green_in, blue_in} == KEY_COLOUR);
            key_out <= key_1;
        end
    end
`endif

    // Level only moves on a vsync rising edge, so it is stable across a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            fade_busy <= 1'b0;
            level_out <= LVL_MAX;
            frame_cnt <= '0;
            vs_prev   <= 1'b0;
        end else begin
            vs_prev <= vsync_in;
            case (state)
                IDLE: begin
                    if (fade_start && fade_dir && level_out != LVL_MAX) begin
                        state     <= FADE_IN;
                        fade_busy <= 1'b1;
                        frame_cnt <= '0;
                    end else if (fade_start && !fade_dir && level_out != '0) begin
                        state     <= FADE_OUT;
                        fade_busy <= 1'b1;
                        frame_cnt <= '0;
                    end
                end
                FADE_IN: begin
                    if (vs_rise) begin
                        if (step_due) begin
                            frame_cnt <= '0;
                            level_out <= level_out + LVL_ONE;
                            if (level_out == LVL_MAX - LVL_ONE) begin
                                state     <= IDLE;
                                fade_busy <= 1'b0;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                FADE_OUT: begin
                    if (vs_rise) begin
                        if (step_due) begin
                            frame_cnt <= '0;
                            level_out <= level_out - LVL_ONE;
                            if (level_out == LVL_ONE) begin
                                state     <= IDLE;
                                fade_busy <= 1'b0;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    fade_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_expand_fade.sv
// tb/tb_rgb_expand_fade.sv - self-checking bench for rgb_expand_fade (1-bit and 2-bit input instances)
module tb_rgb_expand_fade;

    localparam int OB   = 6;
    localparam int FPS  = 2;
    localparam int LMAX = 16;

    logic clk = 1'b0;
    logic reset;
    logic pv, hs, vs, blank, fade_start, fade_dir;
    logic r1, g1, b1;
    logic [1:0] r2, g2, b2;
    logic [OB-1:0] ro1, go1, bo1, ro2, go2, bo2;
    logic hso1, vso1, pvo1, hso2, vso2, pvo2;
    logic busy1, busy2;
    logic [4:0] lvl1, lvl2;
`ifdef RGB_EXPAND_FADE_KEY_EN
    logic key1, key2;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        int r1, g1, b1, r2, g2, b2, hs, vs, pv, blank;
    } pix_t;
    pix_t prev, prev2;

    always #6 clk = ~clk;

    rgb_expand_fade #(.IN_BITS(1), .OUT_BITS(OB), .LEVEL_LOG2(4), .FRAMES_PER_STEP(FPS)) u_dut1 (
`ifdef RGB_EXPAND_FADE_KEY_EN
        .key_out(key1),
`endif
        .clk(clk), .reset(reset), .pix_valid_in(pv),
        .red_in(r1), .green_in(g1), .blue_in(b1),
        .hsync_in(hs), .vsync_in(vs), .blank_in(blank),
        .fade_start(fade_start), .fade_dir(fade_dir),
        .fade_busy(busy1), .level_out(lvl1),
        .red_out(ro1), .green_out(go1), .blue_out(bo1),
        .hsync_out(hso1), .vsync_out(vso1), .pix_valid_out(pvo1)
    );

    rgb_expand_fade #(.IN_BITS(2), .OUT_BITS(OB), .LEVEL_LOG2(4), .FRAMES_PER_STEP(FPS)) u_dut2 (
`ifdef RGB_EXPAND_FADE_KEY_EN
        .key_out(key2),
`endif
        .clk(clk), .reset(reset), .pix_valid_in(pv),
        .red_in(r2), .green_in(g2), .blue_in(b2),
        .hsync_in(hs), .vsync_in(vs), .blank_in(blank),
        .fade_start(fade_start), .fade_dir(fade_dir),
        .fade_busy(busy2), .level_out(lvl2),
        .red_out(ro2), .green_out(go2), .blue_out(bo2),
        .hsync_out(hso2), .vsync_out(vso2), .pix_valid_out(pvo2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Replication as arithmetic: append copies of v until wide enough, drop excess LSBs.
    function automatic int model_pix(int v, int ib, int blk, int lvl);
        int val = 0;
        int bits = 0;
        if (blk != 0) return 0;
        while (bits < OB) begin
            val = val * (1 << ib) + v;
            bits += ib;
        end
        val = val >> (bits - OB);
        return (val * lvl) / LMAX;
    endfunction

    task automatic cycle();
        prev2 = prev;
        prev.r1 = r1; prev.g1 = g1; prev.b1 = b1;
        prev.r2 = r2; prev.g2 = g2; prev.b2 = b2;
        prev.hs = hs; prev.vs = vs; prev.pv = pv; prev.blank = blank;
        @(posedge clk);
        #1;
    endtask

    task automatic check_pipe(input int lvl);
        check("red1",   32'(ro1), model_pix(prev2.r1, 1, prev2.blank, lvl));
        check("green1", 32'(go1), model_pix(prev2.g1, 1, prev2.blank, lvl));
        check("blue1",  32'(bo1), model_pix(prev2.b1, 1, prev2.blank, lvl));
        check("red2",   32'(ro2), model_pix(prev2.r2, 2, prev2.blank, lvl));
        check("green2", 32'(go2), model_pix(prev2.g2, 2, prev2.blank, lvl));
        check("blue2",  32'(bo2), model_pix(prev2.b2, 2, prev2.blank, lvl));
        check("hsync",  32'(hso1), prev2.hs);
        check("vsync",  32'(vso2), prev2.vs);
        check("valid",  32'(pvo1), prev2.pv);
`ifdef RGB_EXPAND_FADE_KEY_EN
        check("key1", 32'(key1), int'(prev2.pv != 0 && prev2.blank == 0 &&
                                      prev2.r1 == 0 && prev2.g1 == 0 && prev2.b1 == 0));
`endif
    endtask

    task automatic randomize_pix(input bit vs_ok);
        r1 = 1'($urandom_range(0, 1)); g1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
        r2 = 2'($urandom_range(0, 3)); g2 = 2'($urandom_range(0, 3)); b2 = 2'($urandom_range(0, 3));
        hs = 1'($urandom_range(0, 1));
        pv = 1'($urandom_range(0, 1));
        blank = ($urandom_range(0, 3) == 0);
        vs = vs_ok ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    task automatic run_pixels(input int n, input int lvl, input bit vs_ok);
        for (int i = 0; i < n; i++) begin
            randomize_pix(vs_ok);
            cycle();
            if (i >= 2) check_pipe(lvl);
        end
        vs = 1'b0;
        cycle();
    endtask

    task automatic vs_edge();
        vs = 1'b1;
        cycle();
        vs = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic set_pix(input logic a, input logic [1:0] c2);
        r1 = a; g1 = a; b1 = a; r2 = c2; g2 = c2; b2 = c2;
    endtask

    initial begin
        reset = 1'b1; pv = 0; hs = 0; vs = 0; blank = 0; fade_start = 0; fade_dir = 0;
        set_pix(1'b0, 2'd0);
        repeat (3) cycle();
        check("rst_level", 32'(lvl1), LMAX);
        check("rst_busy",  32'(busy1), 0);
        check("rst_red",   32'(ro1), 0);
        check("rst_blue2", 32'(bo2), 0);
        check("rst_hsync", 32'(hso1), 0);
        check("rst_valid", 32'(pvo2), 0);
        reset = 1'b0;
        cycle();

        // Directed expansion and exact 2-clk latency
        r1 = 1; g1 = 0; b1 = 1; r2 = 2'b10; g2 = 2'b01; b2 = 2'b11;
        pv = 1; hs = 1;
        cycle();
        check("hs_lat1", 32'(hso1), 0);
        cycle();
        check("dir_red1",   32'(ro1), 63);
        check("dir_green1", 32'(go1), 0);
        check("dir_blue1",  32'(bo1), 63);
        check("dir_red2",   32'(ro2), 42);
        check("dir_green2", 32'(go2), 21);
        check("dir_blue2",  32'(bo2), 63);
        check("hs_lat2",    32'(hso1), 1);
        blank = 1;
        cycle();
        cycle();
        check("blank_red1", 32'(ro1), 0);
        check("blank_red2", 32'(ro2), 0);
        check("blank_blue2", 32'(bo2), 0);
        blank = 0;

        run_pixels(60, LMAX, 1'b1);

        // Fade out 16 -> 0, one level per FPS vsync edges
        fade_start = 1; fade_dir = 0;
        cycle();
        fade_start = 0;
        check("fo_busy0",  32'(busy1), 1);
        check("fo_level0", 32'(lvl1), LMAX);
        for (int n = 1; n <= 32; n++) begin
            vs_edge();
            check("fo_level", 32'(lvl1), (LMAX - n / FPS < 0) ? 0 : LMAX - n / FPS);
            check("fo_level2", 32'(lvl2), (LMAX - n / FPS < 0) ? 0 : LMAX - n / FPS);
            check("fo_busy", 32'(busy1), int'(n < 32));
            if (n == 16) begin
                run_pixels(30, 8, 1'b0);
                set_pix(1'b1, 2'd3); blank = 0; pv = 1;
                cycle();
                cycle();
                check("lvl8_red1", 32'(ro1), 31);
                check("lvl8_red2", 32'(ro2), 31);
            end
        end
        vs_edge();
        vs_edge();
        check("fo_nowrap", 32'(lvl1), 0);
        fade_start = 1; fade_dir = 0;
        cycle();
        fade_start = 0;
        cycle();
        check("fo_at0_busy", 32'(busy1), 0);
        check("fo_at0_level", 32'(lvl1), 0);

        // Fade in 0 -> 16 with an ignored opposite request mid-fade
        fade_start = 1; fade_dir = 1;
        cycle();
        fade_start = 0;
        check("fi_busy0", 32'(busy1), 1);
        for (int n = 1; n <= 32; n++) begin
            vs_edge();
            if (n == 5) begin
                fade_start = 1; fade_dir = 0;
                cycle();
                fade_start = 0;
                check("fi_ignored_busy", 32'(busy1), 1);
            end
            check("fi_level", 32'(lvl1), (n / FPS > LMAX) ? LMAX : n / FPS);
            check("fi_busy", 32'(busy1), int'(n < 32));
        end
        fade_start = 1; fade_dir = 1;
        cycle();
        fade_start = 0;
        cycle();
        check("fi_atmax_busy", 32'(busy1), 0);
        check("fi_atmax_level", 32'(lvl1), LMAX);

        // fade_start on the same cycle as a vsync edge: that edge is not counted
        vs = 1; fade_start = 1; fade_dir = 0;
        cycle();
        vs = 0; fade_start = 0;
        cycle();
        cycle();
        check("coinc_busy", 32'(busy1), 1);
        vs_edge();
        check("coinc_edge1", 32'(lvl1), LMAX);
        vs_edge();
        check("coinc_edge2", 32'(lvl1), LMAX - 1);
        for (int n = 0; n < 20; n++) vs_edge();
        check("mid_level5", 32'(lvl1), 5);

        // Reset mid-fade
        set_pix(1'b1, 2'd3); blank = 0; pv = 1; hs = 1;
        cycle();
        cycle();
        check("lvl5_red1", 32'(ro1), 19);
        reset = 1;
        cycle();
        check("mrst_level", 32'(lvl1), LMAX);
        check("mrst_busy",  32'(busy1), 0);
        check("mrst_red1",  32'(ro1), 0);
        check("mrst_red2",  32'(ro2), 0);
        check("mrst_hsync", 32'(hso1), 0);
        check("mrst_valid", 32'(pvo1), 0);
        reset = 0;
        run_pixels(30, LMAX, 1'b1);

`ifdef RGB_EXPAND_FADE_KEY_EN
        set_pix(1'b0, 2'd0); pv = 1; blank = 0;
        cycle();
        cycle();
        check("key_black1", 32'(key1), 1);
        check("key_black2", 32'(key2), 1);
        blank = 1;
        cycle();
        cycle();
        check("key_blank1", 32'(key1), 0);
        check("key_blank2", 32'(key2), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
